ex_iter_divider: RTL and testbench

//   Parametrised iterative integer divider for the EX stage. Replaces the two vendor

---
 rtl/ex_iter_divider_if.sv | 31 +++
 rtl/ex_iter_divider.sv | 146 ++++++++++++++
 tb/tb_ex_iter_divider.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_iter_divider_if.sv
// Operand/result bus of the iterative divider: request side, result side and flush.
// A transfer happens on a rising clk edge where valid & ready are both high; valid
// never waits on ready, and a producer holds its payload stable until that edge.
interface ex_iter_divider_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quot;
    logic [WIDTH-1:0] out_rem;
    logic [TAG_W-1:0] out_tag;
    logic             out_divz;

    modport master (
        output flush, in_valid, in_signed, in_dividend, in_divisor, in_tag, out_ready,
        input  in_ready, out_valid, out_quot, out_rem, out_tag, out_divz
    );

    modport slave (
        input  flush, in_valid, in_signed, in_dividend, in_divisor, in_tag, out_ready,
        output in_ready, out_valid, out_quot, out_rem, out_tag, out_divz
    );
endinterface

// File: rtl/ex_iter_divider.sv
// Shared signed/unsigned iterative restoring divider for the EX stage, retiring
// STEPS_PER_CYCLE quotient bits per busy cycle, with tag passthrough and flush.
module ex_iter_divider #(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_CYCLE = 1,
    parameter int TAG_W           = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    ex_iter_divider_if.slave     bus,
    output logic [1:0]           dbg_state
);
    localparam int N_ITER = WIDTH / STEPS_PER_CYCLE;
    localparam int CW     = $clog2(N_ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] prem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic             quot_neg_q;
    logic             rem_neg_q;
    logic [TAG_W-1:0] run_tag_q;

    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic [TAG_W-1:0] tag_q;
    logic             divz_q;

    logic             accept;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic             last_step;

    logic [WIDTH-1:0] s_rem;
    logic [WIDTH:0]   s_wide;
    logic [WIDTH-1:0] s_dvd;
    logic [WIDTH-1:0] fin_quot;
    logic [WIDTH-1:0] fin_rem;

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_quot  = quot_q;
    assign bus.out_rem   = rem_q;
    assign bus.out_tag   = tag_q;
    assign bus.out_divz  = divz_q;
    assign dbg_state     = state_q;

    assign accept    = bus.in_valid && bus.in_ready && !bus.flush;
    assign dvd_neg   = bus.in_signed && bus.in_dividend[WIDTH-1];
    assign dvs_neg   = bus.in_signed && bus.in_divisor[WIDTH-1];
    assign dvd_mag   = dvd_neg ? -bus.in_dividend : bus.in_dividend;
    assign dvs_mag   = dvs_neg ? -bus.in_divisor : bus.in_divisor;
    assign last_step = (cnt_q == CW'(1));

    // dvd_q shifts dividend bits out at the top while quotient bits enter at the bottom.
    always_comb begin
        s_rem  = prem_q;
        s_dvd  = dvd_q;
        s_wide = '0;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            s_wide = {s_rem, s_dvd[WIDTH-1]};
            s_dvd  = {s_dvd[WIDTH-2:0], 1'b0};
            if (s_wide >= {1'b0, dvs_q}) begin
                s_wide   = s_wide - {1'b0, dvs_q};
                s_dvd[0] = 1'b1;
            end
            s_rem = s_wide[WIDTH-1:0];
        end
    end

    // MIN / -1 needs no special case: the magnitude wraps back to MIN.
    assign fin_quot = quot_neg_q ? -s_dvd : s_dvd;
    assign fin_rem  = rem_neg_q ? -s_rem : s_rem;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (bus.in_divisor == '0) ? DONE : BUSY;
            BUSY: if (last_step) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            prem_q     <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            run_tag_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            tag_q      <= '0;
            divz_q     <= 1'b0;
        end else if (bus.flush) begin
            cnt_q <= '0;
        end else if (accept) begin
            if (bus.in_divisor == '0) begin
                cnt_q  <= '0;
                quot_q <= '1;
                rem_q  <= bus.in_dividend;
                tag_q  <= bus.in_tag;
                divz_q <= 1'b1;
            end else begin
                cnt_q      <= CW'(N_ITER);
                prem_q     <= '0;
                dvd_q      <= dvd_mag;
                dvs_q      <= dvs_mag;
                quot_neg_q <= dvd_neg ^ dvs_neg;
                rem_neg_q  <= dvd_neg;
                run_tag_q  <= bus.in_tag;
            end
        end else if (state_q == BUSY) begin
            cnt_q  <= cnt_q - CW'(1);
            prem_q <= s_rem;
            dvd_q  <= s_dvd;
            if (last_step) begin
                quot_q <= fin_quot;
                rem_q  <= fin_rem;
                tag_q  <= run_tag_q;
                divz_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ex_iter_divider.sv
// Bench for ex_iter_divider: three instances (1, 2 and 4 steps per cycle) share one
// stimulus bus; sel picks which one receives in_valid and which one is observed.
module tb_ex_iter_divider;
  localparam int W  = 32;
  localparam int T  = 5;
  localparam int EW = 1 + T + W + W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_signed = 1'b0;
  logic [W-1:0] in_dividend = '0;
  logic [W-1:0] in_divisor = '0;
  logic [T-1:0] in_tag = '0;
  logic         out_ready = 1'b1;
  int           sel = 0;

  logic         vld_a [3];
  logic         rdy_a [3];
  logic [W-1:0] quot_a [3];
  logic [W-1:0] rem_a [3];
  logic [T-1:0] tag_a [3];
  logic         divz_a [3];
  logic [1:0]   dbg_a [3];

  for (genvar g = 0; g < 3; g++) begin : u
    ex_iter_divider_if #(.WIDTH(W), .TAG_W(T)) bus ();
    assign bus.flush       = flush;
    assign bus.in_valid    = in_valid && (sel == g);
    assign bus.in_signed   = in_signed;
    assign bus.in_dividend = in_dividend;
    assign bus.in_divisor  = in_divisor;
    assign bus.in_tag      = in_tag;
    assign bus.out_ready   = out_ready;
    assign vld_a[g]  = bus.out_valid;
    assign rdy_a[g]  = bus.in_ready;
    assign quot_a[g] = bus.out_quot;
    assign rem_a[g]  = bus.out_rem;
    assign tag_a[g]  = bus.out_tag;
    assign divz_a[g] = bus.out_divz;
    ex_iter_divider #(.WIDTH(W), .STEPS_PER_CYCLE(1 << g), .TAG_W(T)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .dbg_state (dbg_a[g])
    );
  end

  logic         out_valid, in_ready, out_divz;
  logic [W-1:0] out_quot, out_rem;
  logic [T-1:0] out_tag;
  assign out_valid = vld_a[sel];
  assign in_ready  = rdy_a[sel];
  assign out_quot  = quot_a[sel];
  assign out_rem   = rem_a[sel];
  assign out_tag   = tag_a[sel];
  assign out_divz  = divz_a[sel];

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  // Reference: plain integer division; signed case via 64-bit truncating arithmetic.
  function automatic logic [EW-1:0] model(input logic sg, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [T-1:0] tag);
    logic [W-1:0] q, r;
    longint sa, sb;
    if (b == '0) return {1'b1, tag, a, {W{1'b1}}};
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, tag, r, q};
  endfunction

  function automatic int exp_latency(input logic [W-1:0] b);
    return (b == '0) ? 1 : (W / (1 << sel)) + 1;
  endfunction

  task automatic drive_accept(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [T-1:0] tag);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_in_ready got=%b exp=1 sel=%0d", in_ready, sel);
    end
    in_valid = 1'b1; in_signed = sg; in_dividend = a; in_divisor = b; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_signed = 1'($urandom_range(0, 1));
    in_dividend = $urandom; in_divisor = $urandom; in_tag = T'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic sb_check(input string name, input int lat, input int exp_lat);
    logic [EW-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard_empty got=0 exp>=1", name);
      return;
    end
    e = exp_q.pop_front();
    checks += 5;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL %s latency got=%0d exp=%0d sel=%0d", name, lat, exp_lat, sel);
    end
    if (out_quot !== e[W-1:0]) begin
      errors++; $display("FAIL %s quot got=%h exp=%h", name, out_quot, e[W-1:0]);
    end
    if (out_rem !== e[2*W-1:W]) begin
      errors++; $display("FAIL %s rem got=%h exp=%h", name, out_rem, e[2*W-1:W]);
    end
    if (out_tag !== e[2*W+T-1:2*W]) begin
      errors++; $display("FAIL %s tag got=%h exp=%h", name, out_tag, e[2*W+T-1:2*W]);
    end
    if (out_divz !== e[EW-1]) begin
      errors++; $display("FAIL %s divz got=%b exp=%b", name, out_divz, e[EW-1]);
    end
  endtask

  task automatic run_op(input string name, input logic sg, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [T-1:0] tag);
    int lat;
    drive_accept(sg, a, b, tag);
    wait_valid(lat);
    sb_check(name, lat, exp_latency(b));
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      checks += 6;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      if (out_quot !== '0) begin errors++; $display("FAIL reset_quot got=%h exp=0", out_quot); end
      if (out_rem !== '0) begin errors++; $display("FAIL reset_rem got=%h exp=0", out_rem); end
      if (out_tag !== '0) begin errors++; $display("FAIL reset_tag got=%h exp=0", out_tag); end
      if (out_divz !== 1'b0) begin errors++; $display("FAIL reset_divz got=%b exp=0", out_divz); end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    end
    sel = 0;
  endtask

  task automatic test_directed();
    logic         t_sg [7];
    logic [W-1:0] t_a [7];
    logic [W-1:0] t_b [7];
    logic [W-1:0] t_q [7];
    logic [W-1:0] t_r [7];
    logic         t_z [7];
    logic [T-1:0] tag;
    t_sg[0] = 0; t_a[0] = 32'd100;        t_b[0] = 32'd7;          t_q[0] = 32'd14;         t_r[0] = 32'd2;          t_z[0] = 0;
    t_sg[1] = 1; t_a[1] = 32'hFFFF_FFF9;  t_b[1] = 32'd2;          t_q[1] = 32'hFFFF_FFFD;  t_r[1] = 32'hFFFF_FFFF;  t_z[1] = 0;
    t_sg[2] = 1; t_a[2] = 32'd7;          t_b[2] = 32'hFFFF_FFFE;  t_q[2] = 32'hFFFF_FFFD;  t_r[2] = 32'd1;          t_z[2] = 0;
    t_sg[3] = 0; t_a[3] = 32'hFFFF_FFF9;  t_b[3] = 32'd2;          t_q[3] = 32'h7FFF_FFFC;  t_r[3] = 32'd1;          t_z[3] = 0;
    t_sg[4] = 1; t_a[4] = 32'h8000_0000;  t_b[4] = 32'hFFFF_FFFF;  t_q[4] = 32'h8000_0000;  t_r[4] = 32'd0;          t_z[4] = 0;
    t_sg[5] = 1; t_a[5] = 32'd5;          t_b[5] = 32'd0;          t_q[5] = 32'hFFFF_FFFF;  t_r[5] = 32'd5;          t_z[5] = 1;
    t_sg[6] = 0; t_a[6] = 32'hFFFF_0000;  t_b[6] = 32'd0;          t_q[6] = 32'hFFFF_FFFF;  t_r[6] = 32'hFFFF_0000;  t_z[6] = 1;
    out_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int i = 0; i < 7; i++) begin
        tag = T'(i * 3 + s + 1);
        exp_q.push_back({t_z[i], tag, t_r[i], t_q[i]});
        run_op($sformatf("directed_s%0d_%0d", 1 << s, i), t_sg[i], t_a[i], t_b[i], tag);
      end
    end
    sel = 0;
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] e;
    int lat;
    sel = 0; out_ready = 1'b0;
    e = model(1'b0, 32'd1000, 32'd3, 5'd9);
    drive_accept(1'b0, 32'd1000, 32'd3, 5'd9);
    wait_valid(lat);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL bp_latency got=%0d exp=33", lat); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_dividend = $urandom; in_divisor = 32'd0; in_tag = 5'd31;
      checks += 5;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
      if (out_quot !== e[W-1:0]) begin errors++; $display("FAIL bp_quot got=%h exp=%h", out_quot, e[W-1:0]); end
      if (out_rem !== e[2*W-1:W]) begin errors++; $display("FAIL bp_rem got=%h exp=%h", out_rem, e[2*W-1:W]); end
      if (out_tag !== 5'd9) begin errors++; $display("FAIL bp_tag got=%h exp=9", out_tag); end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic check_quiet(input string name, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL %s out_valid_cycles got=%0d exp=0", name, seen); end
  endtask

  task automatic test_flush();
    int lat;
    sel = 0; out_ready = 1'b1;
    drive_accept(1'b0, 32'd12345, 32'd17, 5'd3);
    repeat (8) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_busy_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_busy_valid got=%b exp=0", out_valid); end
    check_quiet("flush_busy", 40);

    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_signed = 1'b0; in_dividend = 32'd77; in_divisor = 32'd0;
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_ready got=%b exp=1", in_ready); end

    out_ready = 1'b0;
    drive_accept(1'b0, 32'd50, 32'd0, 5'd4);
    wait_valid(lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL flush_done_latency got=%0d exp=1", lat); end
    @(negedge clk); flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_done_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_done_ready got=%b exp=1", in_ready); end

    exp_q.push_back(model(1'b1, 32'hFFFF_FF00, 32'd10, 5'd21));
    run_op("after_flush", 1'b1, 32'hFFFF_FF00, 32'd10, 5'd21);
  endtask

  task automatic test_reset_mid();
    sel = 1; out_ready = 1'b1;
    exp_q.push_back(model(1'b0, 32'd999, 32'd10, 5'd17));
    run_op("pre_reset", 1'b0, 32'd999, 32'd10, 5'd17);
    drive_accept(1'b1, 32'hF000_0001, 32'd3, 5'd6);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks += 6;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready got=%b exp=0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
    if (out_quot !== '0) begin errors++; $display("FAIL rst_mid_quot got=%h exp=0", out_quot); end
    if (out_rem !== '0) begin errors++; $display("FAIL rst_mid_rem got=%h exp=0", out_rem); end
    if (out_tag !== '0) begin errors++; $display("FAIL rst_mid_tag got=%h exp=0", out_tag); end
    if (out_divz !== 1'b0) begin errors++; $display("FAIL rst_mid_divz got=%b exp=0", out_divz); end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_release_ready got=%b exp=1", in_ready); end
    check_quiet("rst_mid", 25);
  endtask

  task automatic test_random();
    logic         sg;
    logic [W-1:0] a, b;
    logic [T-1:0] tag;
    int           kind;
    out_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      sel  = $urandom_range(0, 2);
      sg   = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      a    = $urandom;
      b    = $urandom;
      if (kind == 0) b = '0;
      else if (kind == 1) begin sg = 1'b1; a = 32'h8000_0000; b = '1; end
      else if (kind == 2) b = W'($urandom_range(1, 15));
      else if (kind == 3) b = sg ? -W'($urandom_range(1, 15)) : W'($urandom_range(1, 15));
      else if (kind == 4) a = W'($urandom_range(0, 20));
      tag = T'($urandom);
      exp_q.push_back(model(sg, a, b, tag));
      run_op($sformatf("random_%0d", n), sg, a, b, tag);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
